// File: rtl/counter_pkg.sv
// Shared counter definitions: default geometry and count-direction encoding.
package counter_pkg;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_MODULO = 10;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

endpackage

// File: rtl/t_stage.sv
// One-bit toggle cell: synchronous reset, then parallel load, then toggle on T.
module t_stage (
  input  logic Ck,
  input  logic reset_,
  input  logic T,
  input  logic load,
  input  logic ld_val,
  output logic Q
);

  logic q_reg;

  always_ff @(posedge Ck) begin
    if (reset_) begin
      q_reg <= 1'b0;
    end else if (load) begin
      q_reg <= ld_val;
    end else if (T) begin
      q_reg <= ~q_reg;
    end
  end

  assign Q = q_reg;

endmodule

// File: rtl/toggle_counter.sv
// Modulo-N counter built from per-bit toggle cells with a chainable terminal-count flag.
// Define TOGGLE_COUNTER_UPDOWN_EN to add the dn port and down counting.
module toggle_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int MODULO = DEFAULT_MODULO
) (
  input  logic             Ck,
  input  logic             reset_,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
`ifdef TOGGLE_COUNTER_UPDOWN_EN
  input  logic             dn,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  dir_t             dir;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] wrap_q;

`ifdef TOGGLE_COUNTER_UPDOWN_EN
  assign dir = dir_t'(dn);
`else
  assign dir = DIR_UP;
`endif

  // Out-of-range values wrap as well, so Q can never settle outside 0..MODULO-1.
  always_comb begin
    count_next = Q;
    if (dir == DIR_DN) begin
      count_next = (Q == '0 || Q > TOP) ? TOP : Q - 1'b1;
    end else begin
      count_next = (Q >= TOP) ? '0 : Q + 1'b1;
    end
  end

  assign toggle = en ? (Q ^ count_next) : '0;
  assign ld_val = ({1'b0, din} < MOD_EXT) ? din : '0;
  assign wrap_q = (dir == DIR_DN) ? '0 : TOP;
  assign tc     = en & ~reset_ & (Q == wrap_q);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      t_stage u_stage (
        .Ck    (Ck),
        .reset_(reset_),
        .T     (toggle[gi]),
        .load  (load),
        .ld_val(ld_val[gi]),
        .Q     (Q[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_toggle_counter.sv
// Directed scoreboard bench for toggle_counter (WIDTH=4, MODULO=10).
module tb_toggle_counter;

  localparam int W   = 4;
  localparam int MOD = 10;
`ifdef TOGGLE_COUNTER_UPDOWN_EN
  localparam bit HAS_DN = 1'b1;
`else
  localparam bit HAS_DN = 1'b0;
`endif

  logic         Ck = 1'b0;
  logic         reset_ = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;
  logic         dn_drv = 1'b0;
  logic [W-1:0] Q;
  logic         tc;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];
  string        exp_tag[$];
  logic [W-1:0] model_q;
  bit           model_valid = 1'b0;

  always #5 Ck = ~Ck;

  toggle_counter #(.WIDTH(W), .MODULO(MOD)) dut (
    .Ck    (Ck),
    .reset_(reset_),
    .en    (en),
    .load  (load),
    .din   (din),
`ifdef TOGGLE_COUNTER_UPDOWN_EN
    .dn    (dn_drv),
`endif
    .Q     (Q),
    .tc    (tc)
  );

  function automatic logic [W-1:0] model_next(input logic [W-1:0] q, input logic rst,
                                               input logic ld, input logic [W-1:0] d,
                                               input logic e, input logic down);
    if (rst) return '0;
    if (ld) return (int'(d) < MOD) ? d : '0;
    if (!e) return q;
    if (down) return (q == 0) ? W'(MOD - 1) : q - 1'b1;
    return (int'(q) == MOD - 1) ? '0 : q + 1'b1;
  endfunction

  // One clock: drive inputs, check tc against the model, queue the expected Q, check it after the edge.
  task automatic step(input logic rst, input logic ld, input logic e,
                      input logic [W-1:0] d, input logic down, input string tag);
    logic         exp_tc;
    logic [W-1:0] want;
    logic         dir_dn;
    string        t;
    dir_dn = down & HAS_DN;
    @(negedge Ck);
    reset_ = rst; load = ld; en = e; din = d; dn_drv = dir_dn;
    #1;
    if (rst || model_valid) begin
      exp_tc = !rst && e && (dir_dn ? (model_q == 0) : (int'(model_q) == MOD - 1));
      checks++;
      assert (tc === exp_tc) else begin
        errors++;
        $error("FAIL %s_tc: tc=%0b expected %0b (Q=%0d)", tag, tc, exp_tc, Q);
      end
    end
    exp_q.push_back(model_next(model_q, rst, ld, d, e, dir_dn));
    exp_tag.push_back(tag);
    @(posedge Ck);
    #1;
    want = exp_q.pop_front();
    t = exp_tag.pop_front();
    checks++;
    assert (Q === want) else begin
      errors++;
      $error("FAIL %s_q: Q=%0d expected %0d", t, Q, want);
    end
    $display("step %-8s rst=%0b ld=%0b en=%0b din=%0d dn=%0b -> Q=%0d (exp %0d) tc=%0b",
             t, rst, ld, e, d, dir_dn, Q, want, tc);
    model_q = want;
    model_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d expected completion", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_q = '0;
    // Reset overrides load and en.
    step(1, 1, 1, 4'd7, 0, "reset");
    step(1, 1, 1, 4'd7, 0, "reset");
    // Enable low right after reset: tc stays low.
    step(0, 0, 0, 4'd0, 0, "idle");
    // Count up through the wrap: 1..9,0,1,2.
    for (int i = 0; i < 12; i++) step(0, 0, 1, 4'd0, 0, "upwrap");
    // Loads: in range wins over en, out of range clears.
    step(0, 1, 1, 4'd6, 0, "load6");
    step(0, 1, 1, 4'd12, 0, "load12");
    step(0, 1, 0, 4'd9, 0, "load9");
    step(0, 1, 0, 4'd15, 0, "load15");
    // Hold at 4.
    step(0, 1, 0, 4'd4, 0, "load4");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 4'd0, 0, "hold");
    // Mid-count reset, then resume.
    step(0, 1, 1, 4'd6, 0, "load6");
    step(0, 0, 1, 4'd0, 0, "count7");
    step(1, 0, 1, 4'd0, 0, "midrst");
    step(0, 0, 1, 4'd0, 0, "resume");
    step(0, 0, 1, 4'd0, 0, "resume");
    if (HAS_DN) begin
      // Down wrap: 1 -> 0 -> 9 -> 8, then a same-cycle direction change.
      step(0, 1, 0, 4'd1, 0, "load1");
      for (int i = 0; i < 3; i++) step(0, 0, 1, 4'd0, 1, "dnwrap");
      step(0, 0, 1, 4'd0, 0, "dirup");
      step(0, 0, 1, 4'd0, 1, "dirdn");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
